// File: rtl/phase_pattern_gen.sv
// Phase-to-pattern serializer: maps each accepted one-hot phase to one bit of a
// double-buffered pattern, counts frames and flags malformed phase inputs.
module phase_pattern_gen #(
    parameter int unsigned        N_PHASE     = 16,
    parameter int unsigned        CNT_W       = 8,
    parameter logic [N_PHASE-1:0] RST_PATTERN = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               phase_valid,
    input  logic [N_PHASE-1:0] phase_in,
    input  logic               pat_wr,
    input  logic [N_PHASE-1:0] pat_data,
    output logic               pat_pending,
    output logic [N_PHASE-1:0] active_pat,
    output logic               seq_out,
    output logic               seq_valid,
    output logic               frame_done,
    output logic [CNT_W-1:0]   frame_count,
    output logic               err_onehot
);

    localparam int unsigned PC_W = $clog2(N_PHASE + 1);

    logic [N_PHASE-1:0] shadow;
    logic [PC_W-1:0]    ones_c;
    logic               onehot_c;
    logic               accept_c;
    logic               malformed_c;
    logic               boundary_c;

    logic [N_PHASE-1:0] shadow_nxt;
    logic [N_PHASE-1:0] active_nxt;
    logic               pending_nxt;
    logic               seq_nxt;
    logic               seqv_nxt;
    logic               fd_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               err_nxt;

    // Popcount of the phase bus; exactly one bit set qualifies an accept.
    always_comb begin
        ones_c = '0;
        for (int unsigned i = 0; i < N_PHASE; i++) begin
            ones_c = ones_c + PC_W'(phase_in[i]);
        end
    end

    assign onehot_c    = (ones_c == PC_W'(1));
    assign accept_c    = phase_valid && onehot_c;
    assign malformed_c = phase_valid && !onehot_c;
    assign boundary_c  = accept_c && phase_in[N_PHASE-1];

    // Next-state: a write colliding with a frame boundary commits straight to active.
    always_comb begin
        shadow_nxt  = shadow;
        active_nxt  = active_pat;
        pending_nxt = pat_pending;
        seq_nxt     = seq_out;
        seqv_nxt    = 1'b0;
        fd_nxt      = 1'b0;
        cnt_nxt     = frame_count;
        err_nxt     = err_onehot;

        if (malformed_c) begin
            err_nxt = 1'b1;
        end

        if (accept_c) begin
            seq_nxt  = |(active_pat & phase_in);
            seqv_nxt = 1'b1;
        end

        if (boundary_c) begin
            fd_nxt  = 1'b1;
            cnt_nxt = frame_count + CNT_W'(1);
            if (pat_wr) begin
                active_nxt  = pat_data;
                shadow_nxt  = pat_data;
                pending_nxt = 1'b0;
            end else if (pat_pending) begin
                active_nxt  = shadow;
                pending_nxt = 1'b0;
            end
        end else if (pat_wr) begin
            shadow_nxt  = pat_data;
            pending_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow      <= RST_PATTERN;
            active_pat  <= RST_PATTERN;
            pat_pending <= 1'b0;
            seq_out     <= 1'b0;
            seq_valid   <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            err_onehot  <= 1'b0;
        end else begin
            shadow      <= shadow_nxt;
            active_pat  <= active_nxt;
            pat_pending <= pending_nxt;
            seq_out     <= seq_nxt;
            seq_valid   <= seqv_nxt;
            frame_done  <= fd_nxt;
            frame_count <= cnt_nxt;
            err_onehot  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_phase_pattern_gen.sv
// Bench for phase_pattern_gen: directed phase/pattern sequences checked against a
// behavioural model every cycle, plus hand-computed literal expectations.
module tb_phase_pattern_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        phase_valid;
    logic [15:0] phase_in;
    logic        pat_wr;
    logic [15:0] pat_data;

    logic        pat_pending, seq_out, seq_valid, frame_done, err_onehot;
    logic [15:0] active_pat;
    logic [7:0]  frame_count;

    logic        pat_pending2, seq_out2, seq_valid2, frame_done2, err_onehot2;
    logic [15:0] active_pat2;
    logic [1:0]  frame_count2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    phase_pattern_gen dut (
        .clk(clk), .rst(rst), .phase_valid(phase_valid), .phase_in(phase_in),
        .pat_wr(pat_wr), .pat_data(pat_data), .pat_pending(pat_pending),
        .active_pat(active_pat), .seq_out(seq_out), .seq_valid(seq_valid),
        .frame_done(frame_done), .frame_count(frame_count), .err_onehot(err_onehot)
    );

    phase_pattern_gen #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .phase_valid(phase_valid), .phase_in(phase_in),
        .pat_wr(pat_wr), .pat_data(pat_data), .pat_pending(pat_pending2),
        .active_pat(active_pat2), .seq_out(seq_out2), .seq_valid(seq_valid2),
        .frame_done(frame_done2), .frame_count(frame_count2), .err_onehot(err_onehot2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Behavioural model: pattern state, last sequence bit and total frames seen.
    logic [15:0] m_active  = 16'h0000;
    logic [15:0] m_shadow  = 16'h0000;
    logic        m_pending = 1'b0;
    logic        m_seq     = 1'b0;
    logic        m_seqv    = 1'b0;
    logic        m_fd      = 1'b0;
    logic        m_err     = 1'b0;
    int          m_frames  = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 16'h0000; m_shadow = 16'h0000; m_pending = 1'b0;
            m_seq = 1'b0; m_seqv = 1'b0; m_fd = 1'b0; m_err = 1'b0; m_frames = 0;
        end else begin
            logic boundary;
            boundary = phase_valid && ($countones(phase_in) == 1) && phase_in[15];
            m_seqv = 1'b0;
            m_fd   = 1'b0;
            if (phase_valid && $countones(phase_in) != 1) m_err = 1'b1;
            if (phase_valid && $countones(phase_in) == 1) begin
                m_seq  = (m_active & phase_in) != 16'h0000;
                m_seqv = 1'b1;
            end
            if (boundary) begin
                m_fd = 1'b1;
                m_frames++;
                if (pat_wr) begin
                    m_active = pat_data; m_shadow = pat_data; m_pending = 1'b0;
                end else if (m_pending) begin
                    m_active = m_shadow; m_pending = 1'b0;
                end
            end else if (pat_wr) begin
                m_shadow  = pat_data;
                m_pending = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("cmp_active_pat", active_pat, m_active);
        chk("cmp_pat_pending", pat_pending, m_pending);
        chk("cmp_seq_out", seq_out, m_seq);
        chk("cmp_seq_valid", seq_valid, m_seqv);
        chk("cmp_frame_done", frame_done, m_fd);
        chk("cmp_frame_count", frame_count, m_frames % 256);
        chk("cmp_frame_count_w2", frame_count2, m_frames % 4);
        chk("cmp_err_onehot", err_onehot, m_err);
    end

    task automatic cyc(input logic v, input logic [15:0] ph, input logic wr, input logic [15:0] d);
        phase_valid = v;
        phase_in    = ph;
        pat_wr      = wr;
        pat_data    = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [15:0] pat;

    initial begin
        rst = 1'b1; phase_valid = 1'b0; phase_in = '0; pat_wr = 1'b0; pat_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_active", active_pat, 16'h0000);
        chk("rst_pending", pat_pending, 1'b0);
        chk("rst_count", frame_count, 8'd0);
        chk("rst_err", err_onehot, 1'b0);
        chk("rst_seq_valid", seq_valid, 1'b0);
        rst = 1'b0;

        // Write stays pending through the first frame.
        cyc(1'b0, 16'h0000, 1'b1, 16'hA5A5);
        chk("wr_pending", pat_pending, 1'b1);
        chk("wr_active_held", active_pat, 16'h0000);
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, 16'd1 << k, 1'b0, 16'h0000);
            chk("f1_seq_out", seq_out, 1'b0);
            chk("f1_seq_valid", seq_valid, 1'b1);
        end
        chk("f1_frame_done", frame_done, 1'b1);
        chk("f1_count", frame_count, 8'd1);
        chk("f1_count_w2", frame_count2, 2'd1);
        chk("f1_active", active_pat, 16'hA5A5);
        chk("f1_pending", pat_pending, 1'b0);

        cyc(1'b0, 16'h0000, 1'b0, 16'h0000);
        chk("idle_seq_valid", seq_valid, 1'b0);
        chk("idle_frame_done", frame_done, 1'b0);

        pat = 16'hA5A5;
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, 16'd1 << k, 1'b0, 16'h0000);
            chk("f2_seq_out", seq_out, pat[k]);
        end
        chk("f2_count", frame_count, 8'd2);
        chk("f2_count_w2", frame_count2, 2'd2);

        // Upstream presents phase 0 twice.
        cyc(1'b1, 16'h0001, 1'b0, 16'h0000);
        chk("quirk0a_valid", seq_valid, 1'b1);
        chk("quirk0a_seq", seq_out, 1'b1);
        cyc(1'b1, 16'h0001, 1'b0, 16'h0000);
        chk("quirk0b_valid", seq_valid, 1'b1);
        cyc(1'b1, 16'h0002, 1'b0, 16'h0000);
        chk("quirk1_valid", seq_valid, 1'b1);
        chk("quirk1_seq", seq_out, 1'b0);
        chk("quirk_err", err_onehot, 1'b0);

        // Malformed phases.
        cyc(1'b1, 16'h0000, 1'b0, 16'h0000);
        chk("bad0_err", err_onehot, 1'b1);
        chk("bad0_valid", seq_valid, 1'b0);
        cyc(1'b1, 16'h0011, 1'b0, 16'h0000);
        chk("bad11_err", err_onehot, 1'b1);
        chk("bad11_valid", seq_valid, 1'b0);
        chk("bad11_seq_held", seq_out, 1'b0);
        chk("bad_count", frame_count, 8'd2);
        cyc(1'b1, 16'h0004, 1'b0, 16'h0000);
        chk("after_bad_valid", seq_valid, 1'b1);
        chk("after_bad_seq", seq_out, 1'b1);
        chk("after_bad_err", err_onehot, 1'b1);

        cyc(1'b0, 16'h0000, 1'b1, 16'h5A5A);
        chk("wr2_pending", pat_pending, 1'b1);
        for (int k = 3; k < 16; k++) cyc(1'b1, 16'd1 << k, 1'b0, 16'h0000);
        chk("f3_count", frame_count, 8'd3);
        chk("f3_count_w2", frame_count2, 2'd3);
        chk("f3_active", active_pat, 16'h5A5A);

        // Write colliding with the frame boundary.
        for (int k = 0; k < 15; k++) cyc(1'b1, 16'd1 << k, 1'b0, 16'h0000);
        cyc(1'b1, 16'h8000, 1'b1, 16'hFFFF);
        chk("coll_seq_old_pat", seq_out, 1'b0);
        chk("coll_active", active_pat, 16'hFFFF);
        chk("coll_pending", pat_pending, 1'b0);
        chk("f4_count", frame_count, 8'd4);
        chk("f4_count_w2_wrap", frame_count2, 2'd0);
        cyc(1'b1, 16'h0001, 1'b0, 16'h0000);
        chk("coll_next_seq", seq_out, 1'b1);

        // Reset mid-frame with a pattern pending.
        cyc(1'b0, 16'h0000, 1'b1, 16'h1234);
        for (int k = 1; k < 8; k++) cyc(1'b1, 16'd1 << k, 1'b0, 16'h0000);
        chk("pre_rst_seq", seq_out, 1'b1);
        chk("pre_rst_pending", pat_pending, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mrst_seq_out", seq_out, 1'b0);
        chk("mrst_seq_valid", seq_valid, 1'b0);
        chk("mrst_pending", pat_pending, 1'b0);
        chk("mrst_active", active_pat, 16'h0000);
        chk("mrst_count", frame_count, 8'd0);
        chk("mrst_count_w2", frame_count2, 2'd0);
        chk("mrst_err", err_onehot, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 16'h0001, 1'b0, 16'h0000);
        chk("post_rst_seq", seq_out, 1'b0);
        chk("post_rst_valid", seq_valid, 1'b1);
        chk("post_rst_pending", pat_pending, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
